// File: rtl/percent_scale.sv
// Iterative shift-add scaler: position = period * percent / 2^LONG_PERCENT_WIDTH,
// one multiplier bit per cycle, with valid/ready handshakes on both sides.

package CONFIG;
    localparam int PERIOD_WIDTH       = 16;
    localparam int LONG_PERCENT_WIDTH = 8;
    typedef logic [LONG_PERCENT_WIDTH-1:0] long_percent_t;
endpackage

module percent_scale #(
    parameter int PERIOD_WIDTH       = CONFIG::PERIOD_WIDTH,
    parameter int LONG_PERCENT_WIDTH = CONFIG::LONG_PERCENT_WIDTH,
    parameter bit ROUND              = 1'b0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [PERIOD_WIDTH-1:0]       period,
    input  logic [LONG_PERCENT_WIDTH-1:0] percent,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [PERIOD_WIDTH-1:0]       position,
    output logic                          busy
);

    localparam int ACC_WIDTH = PERIOD_WIDTH + LONG_PERCENT_WIDTH;
    localparam int CNT_WIDTH = (LONG_PERCENT_WIDTH > 1) ? $clog2(LONG_PERCENT_WIDTH) : 1;
    localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(LONG_PERCENT_WIDTH - 1);
    // Half an output LSB in accumulator units; zero when truncating.
    localparam logic [ACC_WIDTH:0] ROUND_BIAS =
        ROUND ? ((ACC_WIDTH+1)'(1) << (LONG_PERCENT_WIDTH - 1)) : '0;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t                         state_q, state_d;
    logic [ACC_WIDTH-1:0]           acc_q, acc_d;
    logic [ACC_WIDTH-1:0]           mcand_q, mcand_d;
    logic [LONG_PERCENT_WIDTH-1:0]  mplier_q, mplier_d;
    logic [CNT_WIDTH-1:0]           cnt_q, cnt_d;
    logic [PERIOD_WIDTH-1:0]        position_q, position_d;

    logic [ACC_WIDTH-1:0]           acc_sum;
    logic [ACC_WIDTH:0]             round_sum;

    // The multiplicand shifts left and the multiplier right each cycle, so the
    // adder always sees period << counter gated by percent[counter].
    always_comb begin
        acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
        round_sum = {1'b0, acc_sum} + ROUND_BIAS;
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        state_d    = state_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        cnt_d      = cnt_q;
        position_d = position_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d  = ACC_WIDTH'(period);
                    mplier_d = percent;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    // Result never exceeds period, so the cast drops only zero bits.
                    position_d = PERIOD_WIDTH'(round_sum >> LONG_PERCENT_WIDTH);
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, matching real hardware.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            cnt_q      <= '0;
            position_q <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            cnt_q      <= cnt_d;
            position_q <= position_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == BUSY) || (state_q == DONE);
    assign position  = position_q;

endmodule

// File: tb/tb_percent_scale.sv
// Scoreboard bench for percent_scale: truncating and rounding instances share
// stimulus; a negedge monitor checks latency, results and handshakes.

module tb_percent_scale;

    localparam int PW = 16;
    localparam int LW = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [PW-1:0] period;
    logic [LW-1:0] percent;
    logic          out_ready;

    logic          in_ready0, out_valid0, busy0;
    logic          in_ready1, out_valid1, busy1;
    logic [PW-1:0] position0, position1;

    percent_scale #(.PERIOD_WIDTH(PW), .LONG_PERCENT_WIDTH(LW), .ROUND(1'b0)) dut0 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
        .period(period), .percent(percent), .out_valid(out_valid0),
        .out_ready(out_ready), .position(position0), .busy(busy0)
    );

    percent_scale #(.PERIOD_WIDTH(PW), .LONG_PERCENT_WIDTH(LW), .ROUND(1'b1)) dut1 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
        .period(period), .percent(percent), .out_valid(out_valid1),
        .out_ready(out_ready), .position(position1), .busy(busy1)
    );

    always #5 clock = ~clock;

    int unsigned cycle = 0;
    always @(posedge clock) cycle <= cycle + 1;

    typedef struct {
        longint      exp0;
        longint      exp1;
        int unsigned acc_cycle;
    } sb_t;

    sb_t sb[$];
    int  n_vec  = 0;
    int  n_fail = 0;
    bit  rand_ready = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Reference: plain integer arithmetic on the mathematical definition.
    function automatic longint ref_trunc(input longint p, input longint f);
        return (p * f) / (longint'(1) << LW);
    endfunction

    function automatic longint ref_round(input longint p, input longint f);
        return (p * f + (longint'(1) << (LW - 1))) / (longint'(1) << LW);
    endfunction

    // Monitor / scoreboard
    bit prev_ov0 = 1'b0, prev_ov1 = 1'b0, hs_pending = 1'b0;

    always @(negedge clock) begin
        if (reset) begin
            sb.delete();
            prev_ov0   = 1'b0;
            prev_ov1   = 1'b0;
            hs_pending = 1'b0;
        end else begin
            if (hs_pending) begin
                check("in_ready0_after_hs", in_ready0, 1);
                check("in_ready1_after_hs", in_ready1, 1);
                hs_pending = 1'b0;
            end
            if (out_valid0 && !prev_ov0) begin
                if (sb.size() == 0) check("spurious_valid0", out_valid0, 0);
                else check("latency0", longint'(cycle - sb[0].acc_cycle), LW);
            end
            if (out_valid1 && !prev_ov1) begin
                if (sb.size() == 0) check("spurious_valid1", out_valid1, 0);
                else check("latency1", longint'(cycle - sb[0].acc_cycle), LW);
            end
            if (out_valid0 && out_ready && sb.size() != 0) begin
                sb_t e;
                e = sb.pop_front();
                check("position_trunc", position0, e.exp0);
                check("out_valid1_with0", out_valid1, 1);
                check("position_round", position1, e.exp1);
                hs_pending = 1'b1;
            end
            if (in_valid && in_ready0) begin
                sb_t e;
                e.exp0      = ref_trunc(period, percent);
                e.exp1      = ref_round(period, percent);
                e.acc_cycle = cycle + 1;
                sb.push_back(e);
            end
            prev_ov0 = out_valid0;
            prev_ov1 = out_valid1;
        end
    end

    always @(posedge clock) begin
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic send(input int p, input int f, input bit hold);
        bit ok = 1'b0;
        period   = PW'(p);
        percent  = LW'(f);
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (in_ready0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", in_ready0, 1);
        @(posedge clock);
        #1;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (sb.size() == 0 && !out_valid0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        period    = '0;
        percent   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        @(negedge clock);
        check("rst_in_ready0", in_ready0, 1);
        check("rst_out_valid0", out_valid0, 0);
        check("rst_position0", position0, 0);
        check("rst_busy0", busy0, 0);
        check("rst_in_ready1", in_ready1, 1);
        check("rst_out_valid1", out_valid1, 0);
        check("rst_position1", position1, 0);
        check("rst_busy1", busy1, 0);

        // Directed values including zero operands and extreme corners
        send(1000, 128, 1'b0);
        drain();
        send(3, 128, 1'b0);
        send(65535, 255, 1'b0);
        send(0, 77, 1'b0);
        send(4321, 0, 1'b0);
        send(65535, 1, 1'b0);
        send(0, 0, 1'b0);
        drain();

        // Backpressure with ignored in_valid pulses during BUSY and DONE
        @(posedge clock);
        #1 out_ready = 1'b0;
        send(12345, 200, 1'b0);
        begin
            bit ok = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(posedge clock);
                #1 in_valid = i[0];
                period  = 16'hFFFF;
                percent = 8'hFF;
                @(negedge clock);
                if (out_valid0) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) check("valid_timeout", out_valid0, 1);
        end
        for (int k = 0; k < 5; k++) begin
            @(posedge clock);
            #1 in_valid = k[0];
            @(negedge clock);
            check("bp_out_valid0", out_valid0, 1);
            check("bp_in_ready0", in_ready0, 0);
            check("bp_busy0", busy0, 1);
            check("bp_hold_pos0", position0, ref_trunc(12345, 200));
            check("bp_hold_pos1", position1, ref_round(12345, 200));
        end
        @(posedge clock);
        #1 in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset during the 4th BUSY cycle aborts with no output
        send(777, 99, 1'b0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            check("abort_out_valid0", out_valid0, 0);
            check("abort_out_valid1", out_valid1, 0);
        end
        check("abort_busy0", busy0, 0);
        send(200, 64, 1'b0);
        drain();

        // Back-to-back with in_valid held high
        send(1234, 77, 1'b1);
        send(40000, 250, 1'b1);
        send(9, 129, 1'b0);
        drain();

        // Randomized operands with random consumer stalls
        rand_ready = 1'b1;
        for (int n = 0; n < 30; n++) begin
            int p, f;
            p = (n % 7 == 0) ? 65535 : int'($urandom_range(0, 65535));
            f = (n % 5 == 0) ? 255 : int'($urandom_range(0, 255));
            send(p, f, ($urandom_range(0, 1) == 1));
        end
        in_valid = 1'b0;
        drain();
        rand_ready = 1'b0;
        #1 out_ready = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
